test_edge_meter: RTL and testbench

Downstream monitor for forwarded test signals such as a clock brought out on a test pin. It samples a single-bit test signal in the system clock domain, synchronizes it, and counts its rising edges over a programmable gate window. It reports the count with a one-cycle valid strobe, plus overflow and stuck flags. It lets on-chip logic or a debug bus confirm that a forwarded signal is alive and toggling at the expected rate.

---
 rtl/test_edge_meter.sv | 126 ++++++++++++
 tb/tb_test_edge_meter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/test_edge_meter.sv
// Edge meter for forwarded test signals: synchronizes test_in, counts rising
// edges over a GATE_CYCLES window and reports count, overflow and stuck flags.
module test_edge_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             overflow,
  output logic             stuck
);

  // GATE_CYCLES must be >= 2; the gate counter just has to hold GATE_CYCLES-1.
  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             overflow_q, overflow_d;
  logic             stuck_q, stuck_d;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= test_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_MEASURE;
      S_MEASURE: if (gate_q == '0) state_d = S_DONE;
      S_DONE:    state_d = cont ? S_MEASURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    cnt_valid = (state_q == S_DONE);
  end

  // A new window starts from IDLE on start, or straight out of DONE in continuous mode.
  assign load = ((state_q == S_IDLE) && start) || ((state_q == S_DONE) && cont);

  always_comb begin
    gate_d     = gate_q;
    edge_d     = edge_q;
    ovf_d      = ovf_q;
    cnt_out_d  = cnt_out_q;
    overflow_d = overflow_q;
    stuck_d    = stuck_q;
    if (load) begin
      gate_d = GATE_LOAD;
      edge_d = '0;
      ovf_d  = 1'b0;
    end else if (state_q == S_MEASURE) begin
      if (gate_q != '0) gate_d = gate_q - 1'b1;
      if (rise) begin
        if (edge_q == CNT_MAX) ovf_d = 1'b1;
        else                   edge_d = edge_q + 1'b1;
      end
      // Last gate cycle: its own rise is included before results are latched.
      if (gate_q == '0) begin
        cnt_out_d  = edge_d;
        overflow_d = ovf_d;
        stuck_d    = (edge_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      cnt_out_q  <= '0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      ovf_q      <= ovf_d;
      cnt_out_q  <= cnt_out_d;
      overflow_q <= overflow_d;
      stuck_q    <= stuck_d;
    end
  end

  assign cnt_out  = cnt_out_q;
  assign overflow = overflow_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_test_edge_meter.sv
// Randomized bench for test_edge_meter: a per-cycle history of test_in is
// kept and each window's edge count is recomputed from it at every DONE.
module tb_test_edge_meter;
  localparam int G   = 100;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          test_in = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          busy;
  logic [CW-1:0] cnt_out;
  logic          cnt_valid;
  logic          overflow;
  logic          stuck;

  test_edge_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .test_in(test_in), .start(start), .cont(cont),
    .busy(busy), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
    .overflow(overflow), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = 3;  // 0 low, 1 high, 2 square of half-period hp, 3 random
  int hp      = 5;
  bit hist [0:16383];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Effective level seen by the meter: a reset cycle flushes the last three samples.
  task automatic tick();
    bit v;
    if (rst) for (int i = 0; i < 3; i++) if (cyc - i >= 0) hist[cyc - i] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       v = 1'b0;
      1:       v = 1'b1;
      2:       v = ((cyc / hp) % 2) == 0;
      default: v = 1'($urandom % 2);
    endcase
    test_in   = v;
    hist[cyc] = v;
  endtask

  function automatic int rises(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++)
      if (c >= 3 && hist[c - 2] && !hist[c - 3]) n++;
    return n;
  endfunction

  // Window occupies t0+1..t0+G; its DONE must land exactly at t0+G+1.
  task automatic wait_done(input int t0, input bit junk, input int drop_k, output int td);
    int n;
    for (int k = 1; k <= G + 1; k++) begin
      tick();
      if (k == 1) chk("busy_rise", busy, 1);
      if (k == drop_k) cont = 1'b0;
      start = (junk && k <= G) ? 1'($urandom % 2) : 1'b0;
      if (k <= G && cnt_valid) chk("early_valid", cnt_valid, 0);
    end
    n = rises(t0 + 1, t0 + G);
    chk("valid", cnt_valid, 1);
    chk("busy_done", busy, 1);
    chk("cnt_out", cnt_out, (n > MAX) ? MAX : n);
    chk("overflow", overflow, n > MAX);
    chk("stuck", stuck, n == 0);
    td = t0 + G + 1;
  endtask

  task automatic single(input bit junk, output int td);
    int t;
    start = 1'b1;
    t = cyc;
    wait_done(t, junk, 0, td);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", cnt_valid, 0);
  endtask

  initial begin
    int td, t, seen;
    hist[0] = 1'b0;

    // Reset with random start and test_in
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom % 2);
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_cnt", cnt_out, 0);
      chk("rst_valid", cnt_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_stuck", stuck, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cnt_valid || busy) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Nominal 5-high/5-low wave
    mode = 2; hp = 5;
    for (int i = 0; i < 5; i++) tick();
    single(0, td);
    chk("nominal_cnt", cnt_out, 10);

    // Stuck high, then stuck low
    mode = 1;
    for (int i = 0; i < 4; i++) tick();
    single(0, td);
    chk("stuck_hi", stuck, 1);
    mode = 0;
    single(0, td);
    chk("stuck_lo_cnt", cnt_out, 0);

    // Saturation with a toggle every cycle, then recovery
    mode = 2; hp = 1;
    single(0, td);
    chk("sat_cnt", cnt_out, MAX);
    chk("sat_ovf", overflow, 1);
    hp = 5;
    single(0, td);
    chk("unsat_cnt", cnt_out, 10);
    chk("unsat_ovf", overflow, 0);

    // Reset at MEASURE cycle 50
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_cnt", cnt_out, 0);
    chk("mid_valid", cnt_valid, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_stuck", stuck, 0);
    seen = 0;
    for (int i = 0; i < G + 5; i++) begin
      tick();
      if (cnt_valid) seen++;
    end
    chk("mid_no_valid", seen, 0);
    single(0, td);

    // Extra starts while busy
    single(1, td);

    // Continuous mode: three back-to-back windows, cont dropped in the third
    cont = 1'b1;
    start = 1'b1;
    t = cyc;
    wait_done(t, 1, 0, td);
    chk("cont_cnt1", cnt_out, 10);
    t = td;
    wait_done(t, 0, 0, td);
    chk("cont_cnt2", cnt_out, 10);
    t = td;
    wait_done(t, 0, G / 2, td);
    tick();
    chk("cont_exit_busy", busy, 0);

    // Random waves and gaps
    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(3, 0);
      hp   = $urandom_range(7, 1);
      for (int i = 0; i < int'($urandom_range(6, 0)); i++) tick();
      single(r[0], td);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
